// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - elapsed-time measurement core counting prescaled ticks from start to stop
//
// Purpose:
//   Measures the interval between start and stop in units of prescaled ticks.
//   A tick occurs every prescaler_value+1 clock cycles. The prescaler value is
//   captured into a shadow register at start, so later changes have no effect
//   on a measurement in progress. The elapsed count saturates instead of
//   wrapping, and a sticky overflow flag records the saturation.
//
// Ports:
//   clk              in   1      system clock, rising edge
//   reset            in   1      synchronous, active-high reset
//   prescaler_value  in   WIDTH  tick period minus one, sampled at start
//   start            in   1      begins a measurement when idle (wins over stop)
//   stop             in   1      ends a measurement when counting (wins over start)
//   elapsed          out  WIDTH  ticks since start; live while running, held after
//   running          out  1      high while counting
//   ready            out  1      high when idle
//   overflow         out  1      sticky; elapsed saturated during this measurement

module stopwatch_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] prescaler_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] elapsed,
  output logic             running,
  output logic             ready,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_presc_shadow;
  logic [WIDTH-1:0] r_presc_ctr;
  logic [WIDTH-1:0] r_elapsed;
  logic             r_overflow;
  logic             r_running;
  logic             r_ready;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_presc_shadow_nxt;
  logic [WIDTH-1:0] w_presc_ctr_nxt;
  logic [WIDTH-1:0] w_elapsed_nxt;
  logic             w_overflow_nxt;
  logic             w_running_nxt;
  logic             w_ready_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_presc_shadow <= '0;
      r_presc_ctr    <= '0;
      r_elapsed      <= '0;
      r_overflow     <= 1'b0;
      r_running      <= 1'b0;
      r_ready        <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_presc_shadow <= w_presc_shadow_nxt;
      r_presc_ctr    <= w_presc_ctr_nxt;
      r_elapsed      <= w_elapsed_nxt;
      r_overflow     <= w_overflow_nxt;
      r_running      <= w_running_nxt;
      r_ready        <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_presc_shadow_nxt = r_presc_shadow;
    w_presc_ctr_nxt    = r_presc_ctr;
    w_elapsed_nxt      = r_elapsed;
    w_overflow_nxt     = r_overflow;
    w_running_nxt      = r_running;
    w_ready_nxt        = r_ready;

    case (r_state)
      ST_IDLE: begin
        // stop is deliberately not looked at here: start wins in idle
        if (start) begin
          w_presc_shadow_nxt = prescaler_value;
          w_presc_ctr_nxt    = prescaler_value;
          w_elapsed_nxt      = '0;
          w_overflow_nxt     = 1'b0;
          w_running_nxt      = 1'b1;
          w_ready_nxt        = 1'b0;
          w_state_nxt        = ST_COUNT;
        end
      end

      ST_COUNT: begin
        // stop freezes everything on the cycle it is seen; start is ignored
        if (stop) begin
          w_state_nxt = ST_DONE;
        end else if (r_presc_ctr != '0) begin
          w_presc_ctr_nxt = r_presc_ctr - ONE;
        end else begin
          w_presc_ctr_nxt = r_presc_shadow;
          if (r_elapsed != '1) begin
            w_elapsed_nxt = r_elapsed + ONE;
          end else begin
            w_overflow_nxt = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_running_nxt = 1'b0;
        w_ready_nxt   = 1'b1;
        w_state_nxt   = ST_IDLE;
      end

      default: begin
        // unused encoding: recover to idle without touching any other register
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign elapsed  = r_elapsed;
  assign running  = r_running;
  assign ready    = r_ready;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - self-checking bench for stopwatch_core (32-bit and 4-bit instances)

`timescale 1ns/1ps

module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [31:0] prescaler_value;

  logic [31:0] elapsed;
  logic        running, ready, overflow;
  logic [3:0]  elapsed_n;
  logic        running_n, ready_n, overflow_n;

  int n_checks = 0;
  int n_errors = 0;

  longint unsigned exp_q[$];
  longint unsigned exp_n_q[$];
  bit              exp_ov_n_q[$];

  always #5 clk = ~clk;

  stopwatch_core #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .prescaler_value(prescaler_value),
    .start(start), .stop(stop), .elapsed(elapsed),
    .running(running), .ready(ready), .overflow(overflow)
  );

  stopwatch_core #(.WIDTH(4)) u_dut_n (
    .clk(clk), .reset(reset), .prescaler_value(prescaler_value[3:0]),
    .start(start), .stop(stop), .elapsed(elapsed_n),
    .running(running_n), .ready(ready_n), .overflow(overflow_n)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at E0, stop sampled at E0+k: the last counting edge is E0+k-1,
  // and elapsed reaches n at E0+n*(p+1).
  function automatic longint unsigned model_count(input int p, input int k, input int w);
    longint unsigned n  = longint'((k - 1) / (p + 1));
    longint unsigned mx = (64'd1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic bit model_ovf(input int p, input int k, input int w);
    longint unsigned n  = longint'((k - 1) / (p + 1));
    longint unsigned mx = (64'd1 << w) - 1;
    return n > mx;
  endfunction

  task automatic do_measure(input int p, input int k, input int p_after);
    prescaler_value = p;
    start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    prescaler_value = p_after;
    exp_q.push_back(model_count(p, k, 32));
    exp_n_q.push_back(model_count(p, k, 4));
    exp_ov_n_q.push_back(model_ovf(p, k, 4));
    repeat (k - 1) tick();
    stop = 1'b1;
    tick();                       // E0+k
    stop = 1'b0;
    tick();
    tick();                       // E0+k+2
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (elapsed !== 32'd0 || running !== 1'b0 || ready !== 1'b1 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got elapsed=%0d running=%b ready=%b overflow=%b, expected 0 0 1 0",
               elapsed, running, ready, overflow);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (ready !== 1'b1 || running !== 1'b0 || elapsed !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_idle_hold: got ready=%b running=%b elapsed=%0d, expected 1 0 0",
               ready, running, elapsed);
    end
  endtask

  task automatic test_basic_p0();
    longint unsigned e, en;
    do_measure(0, 10, 0);
    e  = exp_q.pop_front();
    en = exp_n_q.pop_front();
    void'(exp_ov_n_q.pop_front());
    n_checks++;
    if (elapsed !== e[31:0]) begin
      n_errors++;
      $display("FAIL p0_elapsed: got %0d expected %0d", elapsed, e);
    end
    n_checks++;
    if (running !== 1'b0 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL p0_done_flags: got running=%b ready=%b expected 0 1", running, ready);
    end
    n_checks++;
    if (elapsed_n !== en[3:0]) begin
      n_errors++;
      $display("FAIL p0_elapsed_narrow: got %0d expected %0d", elapsed_n, en);
    end
    repeat (3) tick();
    n_checks++;
    if (elapsed !== e[31:0] || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL p0_held: got elapsed=%0d ready=%b expected %0d 1", elapsed, ready, e);
    end
  endtask

  task automatic test_prescaler();
    longint unsigned e, en;
    do_measure(3, 21, 0);         // prescaler changed to 0 right after start
    e  = exp_q.pop_front();
    en = exp_n_q.pop_front();
    void'(exp_ov_n_q.pop_front());
    n_checks++;
    if (elapsed !== e[31:0]) begin
      n_errors++;
      $display("FAIL p3_elapsed: got %0d expected %0d", elapsed, e);
    end
    n_checks++;
    if (elapsed_n !== en[3:0] || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL p3_narrow_ovf: got elapsed_n=%0d overflow=%b expected %0d 0", elapsed_n, overflow, en);
    end
  endtask

  task automatic test_saturation();
    longint unsigned e, en;
    bit ov;
    do_measure(0, 20, 0);
    e  = exp_q.pop_front();
    en = exp_n_q.pop_front();
    ov = exp_ov_n_q.pop_front();
    n_checks++;
    if (elapsed_n !== en[3:0] || overflow_n !== ov) begin
      n_errors++;
      $display("FAIL sat_narrow: got elapsed=%0d overflow=%b expected %0d %b", elapsed_n, overflow_n, en, ov);
    end
    n_checks++;
    if (elapsed !== e[31:0] || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_wide: got elapsed=%0d overflow=%b expected %0d 0", elapsed, overflow, e);
    end
    prescaler_value = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (elapsed_n !== 4'd0 || overflow_n !== 1'b0 || running_n !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_restart_clear: got elapsed=%0d overflow=%b running=%b expected 0 0 1",
               elapsed_n, overflow_n, running_n);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_priority();
    prescaler_value = 0;
    start = 1'b1;
    stop  = 1'b1;
    tick();                       // E0: start wins in idle
    start = 1'b0;
    stop  = 1'b0;
    n_checks++;
    if (running !== 1'b1 || ready !== 1'b0 || elapsed !== 32'd0) begin
      n_errors++;
      $display("FAIL prio_idle_start_stop: got running=%b ready=%b elapsed=%0d expected 1 0 0",
               running, ready, elapsed);
    end
    repeat (3) tick();            // E0+3
    start = 1'b1;
    tick();                       // E0+4: start ignored while counting
    start = 1'b0;
    n_checks++;
    if (elapsed !== 32'd4 || running !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_start_in_count: got elapsed=%0d running=%b expected 4 1", elapsed, running);
    end
    tick();                       // E0+5
    start = 1'b1;
    stop  = 1'b1;
    tick();                       // E0+6: stop wins, no update
    start = 1'b0;
    stop  = 1'b0;
    tick();
    tick();
    n_checks++;
    if (elapsed !== 32'd5 || ready !== 1'b1 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_count_start_stop: got elapsed=%0d ready=%b running=%b expected 5 1 0",
               elapsed, ready, running);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    n_checks++;
    if (elapsed !== 32'd5 || ready !== 1'b1 || running !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_stop_in_idle: got elapsed=%0d ready=%b running=%b expected 5 1 0",
               elapsed, ready, running);
    end
  endtask

  task automatic test_reset_mid_count();
    longint unsigned e;
    prescaler_value = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (elapsed !== 32'd7) begin
      n_errors++;
      $display("FAIL midrst_pre: got elapsed=%0d expected 7", elapsed);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (elapsed !== 32'd0 || ready !== 1'b1 || running !== 1'b0 || overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_state: got elapsed=%0d ready=%b running=%b overflow=%b expected 0 1 0 0",
               elapsed, ready, running, overflow);
    end
    do_measure(1, 9, 1);
    e = exp_q.pop_front();
    void'(exp_n_q.pop_front());
    void'(exp_ov_n_q.pop_front());
    n_checks++;
    if (elapsed !== e[31:0] || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_after: got elapsed=%0d ready=%b expected %0d 1", elapsed, ready, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    prescaler_value = 32'd0;
    test_reset();
    test_basic_p0();
    test_prescaler();
    test_saturation();
    test_priority();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
